// File: rtl/perf_pkg.sv
// Shared constants for the pipeline performance-counter bank: event channel indices,
// default sizing and the readout select-width helper.
package perf_pkg;

  // Conventional channel assignment used by the core-side event wiring.
  localparam int unsigned EV_CYCLE  = 0;
  localparam int unsigned EV_STALL  = 1;
  localparam int unsigned EV_FLUSH  = 2;
  localparam int unsigned EV_RETIRE = 3;

  localparam int unsigned NUM_EVENTS_DEFAULT = 4;
  localparam int unsigned CNT_WIDTH_DEFAULT  = 32;

  // A single-channel bank still needs a 1-bit select port.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter: synchronous clear, increment qualifier, wrap or saturate at all-ones,
// and a sticky overflow flag.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT,
  parameter int unsigned SATURATE  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  input  logic                 clear_i,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 ovf_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/perf_event_counters.sv
// Bank of NUM_EVENTS pipeline event counters with freeze, clear, snapshot bank and
// indexed readout of live and snapshot values.
module perf_event_counters
  import perf_pkg::*;
#(
  parameter int unsigned  NUM_EVENTS = NUM_EVENTS_DEFAULT,
  parameter int unsigned  CNT_WIDTH  = CNT_WIDTH_DEFAULT,
  parameter int unsigned  SATURATE   = 0,
  localparam int unsigned SEL_W      = sel_width(NUM_EVENTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  freeze_i,
  input  logic                  clear_i,
  input  logic                  snap_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic [CNT_WIDTH-1:0]  snap_o,
  output logic [NUM_EVENTS-1:0] ovf_o,
  output logic                  snap_valid_o
);

  logic [NUM_EVENTS-1:0]                inc;
  logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] cnt;
  logic [NUM_EVENTS-1:0][CNT_WIDTH-1:0] snap_q, snap_d;
  logic                                 snap_valid_q, snap_valid_d;

  assign inc = {NUM_EVENTS{start_i & ~freeze_i}} & event_i;

  for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_cell
    perf_counter_cell #(
      .CNT_WIDTH(CNT_WIDTH),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (inc[k]),
      .clear_i(clear_i),
      .count_o(cnt[k]),
      .ovf_o  (ovf_o[k])
    );
  end

  // Snapshot captures the pre-increment live values; clear wins over capture.
  always_comb begin
    snap_d       = snap_q;
    snap_valid_d = snap_valid_q;
    if (clear_i) begin
      snap_d       = '0;
      snap_valid_d = 1'b0;
    end else if (snap_i) begin
      snap_d       = cnt;
      snap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  // Match-based mux: unused select codes fall through to zero without indexing past the bank.
  always_comb begin
    count_o = '0;
    snap_o  = '0;
    for (int k = 0; k < NUM_EVENTS; k++) begin
      if (sel_i == k[SEL_W-1:0]) begin
        count_o = cnt[k];
        snap_o  = snap_q[k];
      end
    end
  end

  assign snap_valid_o = snap_valid_q;

endmodule

// File: tb/tb_perf_event_counters.sv
// Directed and randomized checks of three counter-bank configurations against a
// behavioural model of counts, snapshots and overflow flags.
module tb_perf_event_counters;

  logic       clk = 1'b0;
  logic       rst, start, freeze, clear, snap;
  logic [3:0] ev;
  logic [1:0] sel;

  logic [3:0] a_cnt, a_snp, a_ovf;
  logic       a_sv;
  logic [3:0] b_cnt, b_snp, b_ovf;
  logic       b_sv;
  logic [7:0] c_cnt, c_snp;
  logic [2:0] c_ovf;
  logic       c_sv;

  int checks   = 0;
  int failures = 0;

  // Instance configs: A = 4ch/4b wrap, B = 4ch/4b saturate, C = 3ch/8b wrap.
  int nev_c[3] = '{4, 4, 3};
  int max_c[3] = '{15, 15, 255};
  int sat_c[3] = '{0, 1, 0};

  int m_cnt[3][4];
  int m_snp[3][4];
  bit m_ovf[3][4];
  bit m_sv[3];

  always #10 clk = ~clk;

  perf_event_counters #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(0)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .event_i(ev), .freeze_i(freeze),
    .clear_i(clear), .snap_i(snap), .sel_i(sel), .count_o(a_cnt), .snap_o(a_snp),
    .ovf_o(a_ovf), .snap_valid_o(a_sv)
  );

  perf_event_counters #(.NUM_EVENTS(4), .CNT_WIDTH(4), .SATURATE(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .event_i(ev), .freeze_i(freeze),
    .clear_i(clear), .snap_i(snap), .sel_i(sel), .count_o(b_cnt), .snap_o(b_snp),
    .ovf_o(b_ovf), .snap_valid_o(b_sv)
  );

  perf_event_counters #(.NUM_EVENTS(3), .CNT_WIDTH(8), .SATURATE(0)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(start), .event_i(ev[2:0]), .freeze_i(freeze),
    .clear_i(clear), .snap_i(snap), .sel_i(sel), .count_o(c_cnt), .snap_o(c_snp),
    .ovf_o(c_ovf), .snap_valid_o(c_sv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_cnt(input int i);
    case (i)
      0:       return {28'd0, a_cnt};
      1:       return {28'd0, b_cnt};
      default: return {24'd0, c_cnt};
    endcase
  endfunction

  function automatic logic [31:0] obs_snp(input int i);
    case (i)
      0:       return {28'd0, a_snp};
      1:       return {28'd0, b_snp};
      default: return {24'd0, c_snp};
    endcase
  endfunction

  function automatic logic [31:0] obs_ovf(input int i);
    case (i)
      0:       return {28'd0, a_ovf};
      1:       return {28'd0, b_ovf};
      default: return {29'd0, c_ovf};
    endcase
  endfunction

  function automatic logic [31:0] obs_sv(input int i);
    case (i)
      0:       return {31'd0, a_sv};
      1:       return {31'd0, b_sv};
      default: return {31'd0, c_sv};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sv[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_cnt[i][k] = 0;
        m_snp[i][k] = 0;
        m_ovf[i][k] = 1'b0;
      end
    end
  endtask

  task automatic model_step(input bit st, input logic [3:0] e, input bit fr, input bit cl,
                            input bit sn);
    for (int i = 0; i < 3; i++) begin
      if (cl) begin
        m_sv[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          m_cnt[i][k] = 0;
          m_snp[i][k] = 0;
          m_ovf[i][k] = 1'b0;
        end
      end else begin
        if (sn) begin
          m_sv[i] = 1'b1;
          for (int k = 0; k < nev_c[i]; k++) m_snp[i][k] = m_cnt[i][k];
        end
        for (int k = 0; k < nev_c[i]; k++) begin
          if (st && !fr && e[k]) begin
            if (m_cnt[i][k] == max_c[i]) begin
              m_ovf[i][k] = 1'b1;
              if (sat_c[i] == 0) m_cnt[i][k] = 0;
            end else begin
              m_cnt[i][k] = m_cnt[i][k] + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] e_ovf;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("%s cnt i%0d s%0d", tag, i, s), obs_cnt(i),
            (s < nev_c[i]) ? 32'(m_cnt[i][s]) : 32'd0);
        chk($sformatf("%s snp i%0d s%0d", tag, i, s), obs_snp(i),
            (s < nev_c[i]) ? 32'(m_snp[i][s]) : 32'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      e_ovf = '0;
      for (int k = 0; k < nev_c[i]; k++) e_ovf[k] = m_ovf[i][k];
      chk($sformatf("%s ovf i%0d", tag, i), obs_ovf(i), e_ovf);
      chk($sformatf("%s sv i%0d", tag, i), obs_sv(i), {31'd0, m_sv[i]});
    end
  endtask

  // Drive one edge's worth of inputs, then return to idle so extra edges change nothing.
  task automatic cycle(input bit st, input logic [3:0] e, input bit fr, input bit cl,
                       input bit sn, input string tag, input int n = 1);
    for (int r = 0; r < n; r++) begin
      @(negedge clk);
      start = st; ev = e; freeze = fr; clear = cl; snap = sn;
      @(posedge clk);
      model_step(st, e, fr, cl, sn);
      #1;
      start = 1'b0; ev = '0; freeze = 1'b0; clear = 1'b0; snap = 1'b0;
      #1;
      check_all(tag);
    end
  endtask

  task automatic read_a(input logic [1:0] s, input string tag, input logic [31:0] e_cnt,
                        input logic [31:0] e_snp);
    sel = s;
    #1;
    chk({tag, " count"}, {28'd0, a_cnt}, e_cnt);
    chk({tag, " snap"}, {28'd0, a_snp}, e_snp);
  endtask

  initial begin
    logic [3:0] re;
    bit rst_, rfr, rcl, rsn;

    rst = 1'b1; start = 1'b0; ev = '0; freeze = 1'b0; clear = 1'b0; snap = 1'b0; sel = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    // Reset mid-count must zero everything without a clock edge.
    cycle(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, "pre_rst", 7);
    read_a(2'd0, "pre_rst a0", 32'd7, 32'd0);
    @(posedge clk);
    #5;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 4'hF, 1'b0, 1'b0, 1'b0, "idle_start0", 5);

    cycle(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, "basic", 10);
    read_a(2'd0, "basic a0", 32'd10, 32'd0);
    read_a(2'd1, "basic a1", 32'd0, 32'd0);
    read_a(2'd2, "basic a2", 32'd10, 32'd0);
    read_a(2'd3, "basic a3", 32'd0, 32'd0);

    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "clr1");
    cycle(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, "ch1_to6", 6);
    cycle(1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, "freeze", 3);
    read_a(2'd1, "freeze a1", 32'd6, 32'd0);
    cycle(1'b1, 4'b0010, 1'b0, 1'b0, 1'b1, "snap_inc");
    read_a(2'd1, "snap_inc a1", 32'd7, 32'd6);
    chk("snap_inc valid", {31'd0, a_sv}, 32'd1);

    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "clr2");
    cycle(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, "wrap", 17);
    read_a(2'd0, "wrap a0", 32'd1, 32'd0);
    chk("wrap a_ovf", {28'd0, a_ovf}, 32'h1);

    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, "clr3");
    cycle(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, "sat", 20);
    sel = 2'd3;
    #1;
    chk("sat b3 count", {28'd0, b_cnt}, 32'd15);
    chk("sat b_ovf", {28'd0, b_ovf}, 32'h8);

    cycle(1'b1, 4'hF, 1'b0, 1'b0, 1'b1, "prefill", 3);
    cycle(1'b1, 4'hF, 1'b0, 1'b1, 1'b1, "clr_prio");
    chk("clr_prio a_sv", {31'd0, a_sv}, 32'd0);
    chk("clr_prio a_ovf", {28'd0, a_ovf}, 32'd0);
    cycle(1'b1, 4'b0111, 1'b0, 1'b0, 1'b1, "c_oob", 2);
    sel = 2'd3;
    #1;
    chk("oob c count", {24'd0, c_cnt}, 32'd0);
    chk("oob c snap", {24'd0, c_snp}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      re  = 4'($urandom);
      rst_ = ($urandom_range(7) != 0);
      rfr = ($urandom_range(3) == 0);
      rcl = ($urandom_range(24) == 0);
      rsn = ($urandom_range(7) == 0);
      cycle(rst_, re, rfr, rcl, rsn, "rand");
      if (n == 200) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rand_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
